seg7_display_driver: RTL
========================

SEG7_DISPLAY_DRIVER -- requirements
Module: seg7_display_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 1024, C cycles per digit-scan step; legal range 2..65536.
REQ-002 Port C  input  1  clock; all state updates on rising edge of C.
REQ-003 Port CLR  input  1  synchronous, active-high reset, sampled on rising edge of C.
REQ-004 Port value  input  8  unsigned binary value to display, sampled on load.
REQ-005 Port load  input  1  single-cycle load strobe, qualified by ready.
REQ-006 Port dec  input  1  display mode sampled with load: 1 = decimal (BCD), 0 = hexadecimal.
REQ-007 Port ready  output  1  high when a load is accepted this cycle.
REQ-008 Port segments  output  8  pattern of the active digit, bit order Dgfedcba, active-high.
REQ-009 Port digit  output  3  one-hot digit enable; bit0 = units, bit1 = tens, bit2 = hundreds.

Function
REQ-010 The FSM SHALL have exactly two states, IDLE and CONV; ready = 1 in IDLE, 0 in CONV.
REQ-011 IDLE, load=1, dec=0, at edge k: all three digit registers written at edge k to {0, value[7:4], value[3:0]}; mode register = hex; state stays IDLE.
REQ-012 IDLE, load=1, dec=1, at edge k: value and mode latched; state -> CONV at edge k.
REQ-013 CONV SHALL run sequential shift-add-3 conversion for exactly 8 edges (k+1..k+8); at edge k+8 all three digit registers written to hundreds/tens/units and state -> IDLE.
REQ-014 Digit registers SHALL change only in a single edge (no partially updated display).
REQ-015 load while ready = 0 SHALL be ignored with no effect on state or registers.
REQ-016 Scan prescaler SHALL count 0..REFRESH_DIV-1 continuously, independent of FSM state; on wrap to 0, digit advances 001 -> 010 -> 100 -> 001.
REQ-017 segments SHALL be combinational from registered digit code, scan pointer and mode only.
REQ-018 Patterns: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (hex).
REQ-019 Blanking: hundreds blanked (segments = 00) when hundreds = 0; tens blanked when hundreds = 0 and tens = 0; units never blanked.
REQ-020 Hex mode: hundreds always blank; decimal point (bit 7) lit on units digit only; decimal mode: bit 7 always 0.
REQ-021 Decimal range 0..255 SHALL convert exactly; no overflow condition exists.

Reset
REQ-022 CLR = 1 at an edge SHALL force: state IDLE, ready 1, digit registers 0, mode decimal, prescaler 0, digit 001, segments 3F.
REQ-023 CLR SHALL take priority over load and over an in-progress conversion; a conversion aborted by CLR SHALL NOT write digit registers.
REQ-024 CLR and load asserted in the same cycle: load SHALL be discarded.

Structure
REQ-025 Shared package seg_pkg SHALL hold the state enumeration, the 16-entry segment pattern table/function, and blank/decimal-point constants.
REQ-026 Conversion SHALL be a sub-module bin2bcd_seq (start, 8-bit in, done, 12-bit BCD out, same C/CLR).
REQ-027 No asynchronous logic, no gated clocks, no latches.

Verification (REFRESH_DIV = 4 in bench)
REQ-028 Reset: CLR high one edge -> ready 1, digit 001, segments 3F; digit steps 001->010->100->001 every 4 edges, tens/hundreds show 00.
REQ-029 Decimal: value 255, dec 1, load at edge k -> ready 0 for edges k+1..k+7, 1 after k+8; scan shows units 6D, tens 6D, hundreds 5B.
REQ-030 Hex: value A7, dec 0 -> units 87, tens 77, hundreds 00, ready stays 1.
REQ-031 Blanking: dec value 7 -> units 07, tens 00, hundreds 00; dec value 100 -> units 3F, tens 3F, hundreds 06.
REQ-032 Abort/ignore: dec load 200, second load 55 at k+3 ignored, CLR at k+4 -> after edge ready 1, all digits blank except units 3F.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display driver: FSM states,
// segment glyph table, blank/decimal-point patterns and digit selects.
package seg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DP    = 8'h80;

  localparam logic [2:0] DIG_UNITS    = 3'b001;
  localparam logic [2:0] DIG_TENS     = 3'b010;
  localparam logic [2:0] DIG_HUNDREDS = 3'b100;

  // Bit order Dgfedcba, active-high.
  function automatic logic [7:0] seg_pattern(input logic [3:0] code);
    logic [7:0] pat;
    case (code)
      4'h0:    pat = 8'h3F;
      4'h1:    pat = 8'h06;
      4'h2:    pat = 8'h5B;
      4'h3:    pat = 8'h4F;
      4'h4:    pat = 8'h66;
      4'h5:    pat = 8'h6D;
      4'h6:    pat = 8'h7D;
      4'h7:    pat = 8'h07;
      4'h8:    pat = 8'h7F;
      4'h9:    pat = 8'h6F;
      4'hA:    pat = 8'h77;
      4'hB:    pat = 8'h7C;
      4'hC:    pat = 8'h39;
      4'hD:    pat = 8'h5E;
      4'hE:    pat = 8'h79;
      default: pat = 8'h71;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per clock.
// done and bcd present the final step combinationally so the caller can commit on that edge.
module bin2bcd_seq (
  input  logic        C,
  input  logic        CLR,
  input  logic        start,
  input  logic [7:0]  bin_in,
  output logic        done,
  output logic [11:0] bcd
);

  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [3:0]  cnt_q;
  logic [11:0] bcd_adj;
  logic [19:0] shifted;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  always_ff @(posedge C) begin
    if (CLR) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (cnt_q != 4'd0) begin
      {bcd_q, bin_q} <= shifted;
      cnt_q          <= cnt_q - 4'd1;
    end else if (start) begin
      bin_q <= bin_in;
      bcd_q <= '0;
      cnt_q <= 4'd8;
    end
  end

  assign done = (cnt_q == 4'd1);
  assign bcd  = shifted[19:8];

endmodule

// File: rtl/seg7_display_driver.sv
// Three-digit multiplexed 7-segment driver with hex or decimal (BCD) display.
// state | meaning
// IDLE  | ready; hex loads commit immediately, decimal loads start conversion
// CONV  | binary-to-BCD conversion running; loads ignored
module seg7_display_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 1024
) (
  input  logic       C,
  input  logic       CLR,
  input  logic [7:0] value,
  input  logic       load,
  input  logic       dec,
  output logic       ready,
  output logic [7:0] segments,
  output logic [2:0] digit
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  state_t        state_q, state_d;
  logic [3:0]    dig_u, dig_t, dig_h;
  logic          mode_dec;
  logic [PW-1:0] presc_q;
  logic [2:0]    scan_q;
  logic          conv_start, conv_done;
  logic [11:0]   conv_bcd;
  logic [3:0]    code;
  logic          blank;

  assign conv_start = (state_q == IDLE) && load && dec;

  bin2bcd_seq u_bin2bcd (
    .C      (C),
    .CLR    (CLR),
    .start  (conv_start),
    .bin_in (value),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  always_ff @(posedge C) begin
    if (CLR) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load && dec) state_d = CONV;
      CONV:    if (conv_done)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE);

  // Display mode flips together with the digits so the scan never mixes old digits with a new mode.
  always_ff @(posedge C) begin
    if (CLR) begin
      dig_u    <= '0;
      dig_t    <= '0;
      dig_h    <= '0;
      mode_dec <= 1'b1;
    end else if (state_q == IDLE && load && !dec) begin
      dig_h    <= 4'd0;
      dig_t    <= value[7:4];
      dig_u    <= value[3:0];
      mode_dec <= 1'b0;
    end else if (state_q == CONV && conv_done) begin
      dig_h    <= conv_bcd[11:8];
      dig_t    <= conv_bcd[7:4];
      dig_u    <= conv_bcd[3:0];
      mode_dec <= 1'b1;
    end
  end

  always_ff @(posedge C) begin
    if (CLR) begin
      presc_q <= '0;
      scan_q  <= DIG_UNITS;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
      scan_q  <= {scan_q[1:0], scan_q[2]};
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  assign digit = scan_q;

  always_comb begin
    code  = dig_u;
    blank = 1'b0;
    case (scan_q)
      DIG_TENS: begin
        code  = dig_t;
        blank = (dig_h == 4'd0) && (dig_t == 4'd0);
      end
      DIG_HUNDREDS: begin
        code  = dig_h;
        blank = !mode_dec || (dig_h == 4'd0);
      end
      default: begin
        code  = dig_u;
        blank = 1'b0;
      end
    endcase
    segments = blank ? SEG_BLANK : seg_pattern(code);
    if (!mode_dec && scan_q == DIG_UNITS) segments = segments | SEG_DP;
  end

endmodule
